// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator (I/S/B/J/U/Z) with a 2-entry output FIFO.
// Define IMM_GEN_OPCODE_DECODE_EN to derive the format from the opcode instead of in_immsrc.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  logic [2:0]      fmt;
  logic [31:0]     imm32;
  logic            illegal;
  logic [XLEN-1:0] imm_x;

`ifdef IMM_GEN_OPCODE_DECODE_EN
  logic unused_immsrc;
  assign unused_immsrc = ^in_immsrc;

  // SYSTEM opcode: funct3[2] separates CSR immediate forms (zimm) from register forms.
  always_comb begin
    fmt = 3'b110;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: fmt = 3'b000;
      7'b0100011:                         fmt = 3'b001;
      7'b1100011:                         fmt = 3'b010;
      7'b1101111:                         fmt = 3'b011;
      7'b0110111, 7'b0010111:             fmt = 3'b100;
      7'b1110011:                         fmt = in_instr[14] ? 3'b101 : 3'b000;
      default:                            fmt = 3'b110;
    endcase
  end
`else
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];
  assign fmt = in_immsrc;
`endif

  always_comb begin
    imm32   = 32'd0;
    illegal = 1'b0;
    case (fmt)
      3'b000:  imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      3'b001:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      3'b010:  imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011:  imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      3'b100:  imm32 = {in_instr[31:12], 12'd0};
      3'b101:  imm32 = {27'd0, in_instr[19:15]};
      default: illegal = 1'b1;
    endcase
  end

  // Bit 31 of imm32 already carries the correct extension bit for every format (0 for Z).
  generate
    if (XLEN == 64) begin : g_x64
      assign imm_x = {{32{imm32[31]}}, imm32};
    end else begin : g_x32
      assign imm_x = imm32;
    end
  endgenerate

  logic [XLEN-1:0] imm_q [2];
  logic [1:0]      ill_q;
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign in_ready    = (count != 2'd2);
  assign out_valid   = (count != 2'd0);
  assign out_imm     = imm_q[rptr];
  assign out_illegal = ill_q[rptr];
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q[0] <= '0;
      imm_q[1] <= '0;
      ill_q    <= 2'b00;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        imm_q[wptr] <= imm_x;
        ill_q[wptr] <= illegal;
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
